// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART receive controller
package uart_pkg;

   localparam int Oversample = 16;
   localparam int DivWidthDef = 16;
   localparam logic [7:0] ErrMax = 8'hFF;

   typedef enum logic {
      DISARMED = 1'b0,
      ARMED    = 1'b1
   } idleState_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - byte FIFO between receiver capture and the drain port
module uart_byte_fifo #(
   parameter int Depth = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [7:0]             pushData,
   input  logic                   pop,
   output logic [7:0]             headData,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(Depth):0] level
);

   localparam int PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullLvl = (PtrW + 1)'(Depth);

   logic [7:0]      mem [Depth];
   logic [PtrW-1:0] wrPtr;
   logic [PtrW-1:0] rdPtr;
   logic [PtrW:0]   count;
   logic            doPush;
   logic            doPop;

   assign empty    = (count == '0);
   assign full     = (count == FullLvl);
   assign level    = count;
   assign headData = mem[rdPtr];

   // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
   assign doPop  = pop & ~empty;
   assign doPush = push & (~full | doPop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencing: oversample strobe, byte capture,
// drain FIFO, sticky status and line-idle timeout
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DivWidth  = DivWidthDef,
   parameter int Depth     = 4,
   parameter int IdleTicks = 10 * Oversample
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DivWidth-1:0]    divisor,
   input  logic                   clr_status,
   output logic                   rx_en,
   input  logic [7:0]             rx_data,
   input  logic                   rx_done,
   input  logic                   rx_err,
   output logic [7:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(Depth):0] level,
   output logic                   overflow,
   output logic                   frame_err,
   output logic [7:0]             err_count,
   output logic                   idle
);

   localparam int IdleW = $clog2(IdleTicks);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleTicks - 1);

   logic [DivWidth-1:0] tickCnt;
   logic                tickHit;
   logic                cap;
   logic                ev;
   logic                popReq;
   logic                fifoFull;
   logic                fifoEmpty;
   logic                drop;
   logic [7:0]          errBase;
   idleState_t          idleState;
   logic [IdleW-1:0]    idleCnt;
   logic [IdleW-1:0]    idleInc;

   // Decoded from the registered count; >= lets a lowered divisor wrap at once.
   assign tickHit = (tickCnt >= divisor);
   assign rx_en   = enable & tickHit & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tickCnt <= '0;
      end else if (!enable || tickHit) begin
         tickCnt <= '0;
      end else begin
         tickCnt <= tickCnt + 1'b1;
      end
   end

   assign cap    = rx_en & rx_done;
   assign ev     = rx_en & rx_err;
   assign popReq = out_valid & out_ready;
   assign drop   = cap & fifoFull & ~popReq;

   uart_byte_fifo #(
      .Depth(Depth)
   ) byteFifo (
      .clk     (clk),
      .reset   (reset),
      .push    (cap),
      .pushData(rx_data),
      .pop     (popReq),
      .headData(out_data),
      .full    (fifoFull),
      .empty   (fifoEmpty),
      .level   (level)
   );

   assign out_valid = ~fifoEmpty;

   // Clear is applied first so a coincident event still lands.
   assign errBase = clr_status ? 8'h00 : err_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
         err_count <= 8'h00;
      end else begin
         overflow  <= (overflow & ~clr_status) | drop;
         frame_err <= (frame_err & ~clr_status) | ev;
         if (ev && errBase != ErrMax) begin
            err_count <= errBase + 1'b1;
         end else begin
            err_count <= errBase;
         end
      end
   end

   assign idleInc = idleCnt + 1'b1;

   // Fires as the tick count reaches IdleTicks-1, putting the pulse IdleTicks ticks after the byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idleState <= DISARMED;
         idleCnt   <= '0;
         idle      <= 1'b0;
      end else begin
         idle <= 1'b0;
         if (ev) begin
            idleState <= DISARMED;
            idleCnt   <= '0;
         end else if (cap) begin
            idleState <= ARMED;
            idleCnt   <= '0;
         end else if (idleState == ARMED && rx_en) begin
            if (idleInc == IdleLast) begin
               idle      <= 1'b1;
               idleState <= DISARMED;
               idleCnt   <= '0;
            end else begin
               idleCnt <= idleInc;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] divisor;
   logic        clr_status;
   logic        rx_en;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        rx_err;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic        overflow;
   logic        frame_err;
   logic [7:0]  err_count;
   logic        idle;

   int checks = 0;
   int errors = 0;

   uart_rx_ctrl #(
      .DivWidth (16),
      .Depth    (4),
      .IdleTicks(160)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .divisor   (divisor),
      .clr_status(clr_status),
      .rx_en     (rx_en),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_err    (rx_err),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .frame_err (frame_err),
      .err_count (err_count),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_rx_en"},     rx_en,     0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"},  out_data,  0);
      check({tag, "_level"},     level,     0);
      check({tag, "_overflow"},  overflow,  0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_err_count"}, err_count, 0);
      check({tag, "_idle"},      idle,      0);
   endtask

   task automatic waitEn(input logic want);
      int n = 0;
      #1;
      while (rx_en !== want && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("align_rx_en", rx_en, want);
   endtask

   task automatic pushByte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   initial begin
      logic [4:0] expA;
      logic [3:0] expB;
      int hits;
      int firstK;

      reset = 1'b1; enable = 1'b0; divisor = '0; clr_status = 1'b0;
      rx_data = '0; rx_done = 1'b0; rx_err = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      checkAllZero("reset");

      // divisor 3: counts 1,2,3,0,1 at the following negedges
      reset = 1'b0; enable = 1'b1; divisor = 16'd3;
      expA = 5'b00100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("tick_div3", rx_en, expA[i]);
      end
      @(negedge clk);
      check("tick_cnt2", rx_en, 0);
      divisor = 16'd1;
      #1;
      check("tick_lower_wrap", rx_en, 1);
      expB = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("tick_div1", rx_en, expB[i]);
      end
      divisor = 16'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("tick_div0", rx_en, 1);
      end

      // capture: off-tick rx_done ignored, on-tick byte visible next cycle
      divisor = 16'd1;
      waitEn(1'b0);
      rx_done = 1'b1; rx_data = 8'h5A;
      @(negedge clk);
      check("offtick_level", level, 0);
      check("offtick_valid", out_valid, 0);
      check("ontick_align", rx_en, 1);
      rx_data = 8'hA5;
      @(negedge clk);
      rx_done = 1'b0;
      check("cap_valid", out_valid, 1);
      check("cap_data", out_data, 8'hA5);
      check("cap_level", level, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_level", level, 0);
      check("drain_valid", out_valid, 0);

      // overflow: five pushes into four entries
      divisor = 16'd0;
      for (int i = 1; i <= 5; i++) pushByte(8'(i));
      check("ovf_level", level, 4);
      check("ovf_flag", overflow, 1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf_pop_data", out_data, i);
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("ovf_empty", out_valid, 0);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      check("ovf_clr", overflow, 0);

      // push into full with a coincident pop
      for (int i = 1; i <= 4; i++) pushByte(8'(i));
      out_ready = 1'b1;
      pushByte(8'h05);
      out_ready = 1'b0;
      check("fullpop_level", level, 4);
      check("fullpop_ovf", overflow, 0);
      for (int i = 2; i <= 5; i++) begin
         check("fullpop_data", out_data, i);
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("fullpop_empty", level, 0);

      // errors saturate; clear with coincident event counts one
      rx_err = 1'b1;
      repeat (300) @(negedge clk);
      rx_err = 1'b0;
      check("err_sat", err_count, 8'hFF);
      check("err_frame", frame_err, 1);
      rx_err = 1'b1; clr_status = 1'b1;
      @(negedge clk);
      rx_err = 1'b0; clr_status = 1'b0;
      check("clr_ev_count", err_count, 1);
      check("clr_ev_frame", frame_err, 1);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      check("clr_count", err_count, 0);
      check("clr_frame", frame_err, 0);

      // idle fires 160 cycles after the byte tick, once
      pushByte(8'hC3);
      hits = 0; firstK = 0;
      for (int k = 1; k <= 200; k++) begin
         if (idle === 1'b1) begin
            hits++;
            if (firstK == 0) firstK = k;
         end
         @(negedge clk);
      end
      check("idle_first", firstK, 160);
      check("idle_once", hits, 1);
      check("idle_byte", out_data, 8'hC3);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // async reset with level 3 and overflow set
      for (int i = 0; i < 5; i++) pushByte(8'(8'h11 + i));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("pre_rst_level", level, 3);
      check("pre_rst_ovf", overflow, 1);
      #2 reset = 1'b1;
      #1;
      checkAllZero("async_rst");
      @(negedge clk);
      reset = 1'b0;

      // no byte since reset: idle stays quiet
      hits = 0;
      repeat (200) begin
         @(negedge clk);
         if (idle === 1'b1) hits++;
      end
      check("idle_never", hits, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
